// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use scoreboard.
// Slot fields are sized for the widest supported configuration; narrower ones zero-extend.
package fwd_pkg;

    localparam int AW_MAX = 8;
    localparam int SW_MAX = 4;

    localparam int RDY_ALU  = 0;
    localparam int RDY_LOAD = 1;

    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef struct packed {
        logic              v;
        logic              we;
        logic [AW_MAX-1:0] rd;
        logic [SW_MAX-1:0] rdy_stg;
    } slot_t;

endpackage

// File: rtl/fwd_port_match.sv
// Priority search over the in-flight slots for one source operand.
// Reports the youngest producer and whether its result is still outstanding.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int FW    = 2
) (
    input  slot_t          slots [DEPTH],
    input  logic [AW-1:0]  addr,
    input  logic           rd_use,
    output logic [FW-1:0]  sel,
    output logic           hazard
);

    // Walk oldest to youngest so the last hit (lowest k) is the one kept.
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slots[k].v && slots[k].we && rd_use && (addr != '0) &&
                (slots[k].rd == AW_MAX'(addr))) begin
                sel    = FW'(k + 1);
                hazard = (int'(slots[k].rdy_stg) > k);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: a shift register of in-flight destination
// tags, one priority matcher per read port, stall generation and a stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int NRD   = 2,
    parameter  int AW    = 5,
    parameter  int CNTW  = 16,
    localparam int SW    = $clog2(DEPTH),
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic              iss_we,
    input  logic [AW-1:0]     iss_rd,
    input  logic [SW-1:0]     iss_rdy_stg,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_use,
    input  logic              flush,
    output logic [NRD*FW-1:0] fwd_sel,
    output logic              stall,
    output logic [CNTW-1:0]   stall_cnt
);

    slot_t          slots [DEPTH];
    slot_t          issue_slot;
    logic [NRD-1:0] port_hazard;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_port_match #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .FW    (FW)
        ) u_match (
            .slots  (slots),
            .addr   (rd_addr[p*AW +: AW]),
            .rd_use (rd_use[p]),
            .sel    (fwd_sel[p*FW +: FW]),
            .hazard (port_hazard[p])
        );
    end

    // flush overrides the hazard: the killed instruction never needs its operands.
    assign stall = (|port_hazard) & iss_valid & ~flush;

    always_comb begin
        issue_slot         = '0;
        issue_slot.v       = iss_valid & ~stall & ~flush;
        issue_slot.we      = iss_we;
        issue_slot.rd      = AW_MAX'(iss_rd);
        issue_slot.rdy_stg = SW_MAX'(iss_rdy_stg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                slots[k] <= slots[k-1];
            end
            slots[SLOT_EX] <= issue_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus a randomized
// run against a history-based model of issued instructions.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int DEPTH = 3;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int CNTW  = 2;
    localparam int SW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int CMAX  = (1 << CNTW) - 1;

    logic              clk;
    logic              rst_n;
    logic              iss_valid;
    logic              iss_we;
    logic [AW-1:0]     iss_rd;
    logic [SW-1:0]     iss_rdy_stg;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_use;
    logic              flush;
    logic [NRD*FW-1:0] fwd_sel;
    logic              stall;
    logic [CNTW-1:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;

    fwd_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .AW    (AW),
        .CNTW  (CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_we      (iss_we),
        .iss_rd      (iss_rd),
        .iss_rdy_stg (iss_rdy_stg),
        .rd_addr     (rd_addr),
        .rd_use      (rd_use),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // hist[0] is the instruction accepted at the most recent edge (age 0).
    typedef struct {
        bit v;
        bit we;
        int rd;
        int rdy;
    } ent_t;

    ent_t hist[$];
    int   m_cnt;
    int   exp_sel [NRD];
    bit   exp_stall;
    logic [NRD*FW-1:0] exp_q[$];

    function automatic void model_eval();
        bit hz;
        int a;
        hz = 0;
        for (int p = 0; p < NRD; p++) begin
            exp_sel[p] = 0;
            a = int'(rd_addr[p*AW +: AW]);
            if (rd_use[p] && a != 0) begin
                for (int age = 0; age < hist.size(); age++) begin
                    if (hist[age].v && hist[age].we && hist[age].rd == a) begin
                        exp_sel[p] = age + 1;
                        // Producer finishes after `rdy` more stages; age says how many it has done.
                        if (hist[age].rdy > age) hz = 1;
                        break;
                    end
                end
            end
        end
        exp_stall = hz && iss_valid && !flush;
    endfunction

    function automatic void model_clear();
        hist.delete();
        m_cnt = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        iss_valid   = 1'b0;
        iss_we      = 1'b0;
        iss_rd      = '0;
        iss_rdy_stg = '0;
        rd_addr     = '0;
        rd_use      = '0;
        flush       = 1'b0;
    endtask

    task automatic issue(input bit v, input bit we, input int rd, input int rdy);
        iss_valid   = v;
        iss_we      = we;
        iss_rd      = AW'(rd);
        iss_rdy_stg = SW'(rdy);
    endtask

    task automatic read(input int p, input int addr, input bit en);
        rd_addr[p*AW +: AW] = AW'(addr);
        rd_use[p]           = en;
    endtask

    task automatic tick();
        ent_t e;
        model_eval();
        @(posedge clk);
        if (rst_n) begin
            e.v   = iss_valid && !exp_stall && !flush;
            e.we  = iss_we;
            e.rd  = int'(iss_rd);
            e.rdy = int'(iss_rdy_stg);
            hist.push_front(e);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            if (exp_stall && m_cnt < CMAX) m_cnt++;
        end
        @(negedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        issue(1, 1, 5, RDY_ALU);
        tick();
        read(0, 5, 1);
        #1;
        checks++;
        if (fwd_sel[FW-1:0] !== FW'(1)) begin
            failures++;
            $display("FAIL reset_pre_sel: got %0d required 1", fwd_sel[FW-1:0]);
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_async: sel=%0h stall=%0b cnt=%0d required 0/0/0", fwd_sel, stall, stall_cnt);
        end
        iss_valid   = 1'b1;
        iss_we      = 1'b1;
        iss_rd      = AW'($urandom_range(1, 31));
        iss_rdy_stg = SW'(RDY_LOAD);
        rd_addr     = NRD*AW'($urandom);
        rd_use      = '1;
        @(posedge clk);
        #1;
        checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_held: sel=%0h stall=%0b cnt=%0d required 0/0/0", fwd_sel, stall, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        read(0, 5, 1);
        iss_valid = 1'b1;
        #1;
        checks++;
        if (fwd_sel !== '0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_r5: sel=%0h stall=%0b required 0/0", fwd_sel, stall);
        end
        tick();
    endtask

    task automatic test_alu_b2b();
        do_reset();
        issue(1, 1, 3, RDY_ALU);
        tick();
        issue(1, 0, 0, RDY_ALU);
        read(0, 3, 1);
        #1;
        checks++;
        if (fwd_sel[FW-1:0] !== FW'(1) || stall !== 1'b0) begin
            failures++;
            $display("FAIL alu_b2b_c1: sel=%0d stall=%0b required 1/0", fwd_sel[FW-1:0], stall);
        end
        tick();
        issue(1, 0, 0, RDY_ALU);
        read(0, 3, 1);
        #1;
        checks++;
        if (fwd_sel[FW-1:0] !== FW'(2) || stall !== 1'b0) begin
            failures++;
            $display("FAIL alu_b2b_c2: sel=%0d stall=%0b required 2/0", fwd_sel[FW-1:0], stall);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 1, 4, RDY_LOAD);
        tick();
        issue(1, 1, 9, RDY_ALU);
        read(0, 4, 1);
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_sel[FW-1:0] !== FW'(1)) begin
            failures++;
            $display("FAIL load_use_stall: stall=%0b sel=%0d required 1/1", stall, fwd_sel[FW-1:0]);
        end
        tick();
        checks++;
        if (stall_cnt !== CNTW'(1)) begin
            failures++;
            $display("FAIL load_use_cnt: got %0d required 1", stall_cnt);
        end
        issue(1, 1, 9, RDY_ALU);
        read(0, 4, 1);
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_sel[FW-1:0] !== FW'(2)) begin
            failures++;
            $display("FAIL load_use_resume: stall=%0b sel=%0d required 0/2", stall, fwd_sel[FW-1:0]);
        end
        tick();
        // The held instruction was accepted once; r9 is now its youngest producer.
        read(1, 9, 1);
        #1;
        checks++;
        if (fwd_sel[FW +: FW] !== FW'(1) || stall_cnt !== CNTW'(1)) begin
            failures++;
            $display("FAIL load_use_after: sel1=%0d cnt=%0d required 1/1", fwd_sel[FW +: FW], stall_cnt);
        end
        tick();
    endtask

    task automatic test_youngest();
        do_reset();
        issue(1, 1, 7, RDY_ALU);
        tick();
        issue(1, 1, 7, RDY_ALU);
        tick();
        issue(1, 0, 0, RDY_ALU);
        read(1, 7, 1);
        #1;
        checks++;
        if (fwd_sel[FW +: FW] !== FW'(1)) begin
            failures++;
            $display("FAIL youngest_first: got %0d required 1", fwd_sel[FW +: FW]);
        end
        tick();
        read(1, 7, 1);
        #1;
        checks++;
        if (fwd_sel[FW +: FW] !== FW'(2) || stall !== 1'b0) begin
            failures++;
            $display("FAIL youngest_next: sel=%0d stall=%0b required 2/0", fwd_sel[FW +: FW], stall);
        end
        tick();
        tick();
        // Both producers have now left slot DEPTH-1; the register file supplies r7.
        read(1, 7, 1);
        #1;
        checks++;
        if (fwd_sel[FW +: FW] !== FW'(0)) begin
            failures++;
            $display("FAIL youngest_retired: got %0d required 0", fwd_sel[FW +: FW]);
        end
        tick();
    endtask

    task automatic test_r0_and_use();
        do_reset();
        issue(1, 1, 0, RDY_LOAD);
        tick();
        issue(1, 1, 6, RDY_ALU);
        read(0, 0, 1);
        #1;
        checks++;
        if (fwd_sel[FW-1:0] !== FW'(0) || stall !== 1'b0) begin
            failures++;
            $display("FAIL r0_never_fwd: sel=%0d stall=%0b required 0/0", fwd_sel[FW-1:0], stall);
        end
        tick();
        issue(1, 0, 0, RDY_ALU);
        read(0, 6, 0);
        read(1, 6, 1);
        #1;
        checks++;
        if (fwd_sel[FW-1:0] !== FW'(0) || fwd_sel[FW +: FW] !== FW'(1)) begin
            failures++;
            $display("FAIL rd_use_gate: sel0=%0d sel1=%0d required 0/1", fwd_sel[FW-1:0], fwd_sel[FW +: FW]);
        end
        tick();
    endtask

    task automatic test_flush_sat();
        do_reset();
        issue(1, 1, 4, RDY_LOAD);
        tick();
        issue(1, 1, 8, RDY_ALU);
        read(0, 4, 1);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: got %0b required 0", stall);
        end
        tick();
        read(0, 4, 1);
        read(1, 8, 1);
        #1;
        checks++;
        if (fwd_sel[FW-1:0] !== FW'(2) || fwd_sel[FW +: FW] !== FW'(0) || stall_cnt !== '0) begin
            failures++;
            $display("FAIL flush_bubble: sel0=%0d sel1=%0d cnt=%0d required 2/0/0",
                     fwd_sel[FW-1:0], fwd_sel[FW +: FW], stall_cnt);
        end
        tick();

        // Chain of loads, each consuming the previous one: one stall per link.
        do_reset();
        issue(1, 1, 1, RDY_LOAD);
        tick();
        for (int i = 1; i <= 5; i++) begin
            issue(1, 1, i + 1, RDY_LOAD);
            read(0, i, 1);
            tick();
            issue(1, 1, i + 1, RDY_LOAD);
            read(0, i, 1);
            tick();
            checks++;
            if (stall_cnt !== CNTW'((i < CMAX) ? i : CMAX)) begin
                failures++;
                $display("FAIL stall_sat_%0d: got %0d required %0d", i, stall_cnt, (i < CMAX) ? i : CMAX);
            end
        end
    endtask

    task automatic test_random();
        logic [NRD*FW-1:0] exp_vec;
        logic [NRD*FW-1:0] got_vec;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1 ? RDY_LOAD : RDY_ALU);
            for (int p = 0; p < NRD; p++) begin
                read(p, $urandom_range(0, 7), $urandom_range(0, 4) != 0);
            end
            flush = ($urandom_range(0, 7) == 0);
            #1;
            model_eval();
            for (int p = 0; p < NRD; p++) exp_vec[p*FW +: FW] = FW'(exp_sel[p]);
            exp_q.push_back(exp_vec);
            got_vec = fwd_sel;
            exp_vec = exp_q.pop_front();
            checks++;
            if (got_vec !== exp_vec || stall !== exp_stall || stall_cnt !== CNTW'(m_cnt)) begin
                failures++;
                $display("FAIL random_c%0d: sel=%0h stall=%0b cnt=%0d required %0h/%0b/%0d",
                         c, got_vec, stall, stall_cnt, exp_vec, exp_stall, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_youngest();
        test_r0_and_use();
        test_flush_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
